// File: rtl/period_averager.sv
// Block averager for period samples: sums 2^k unsigned periods and emits the
// truncated mean on an AXI-Stream style output, one result per block.
module period_averager #(
    parameter int AXIS_TDATA_WIDTH = 32
) (
    input  logic                        SYS_aclk,
    input  logic                        SYS_aresetn,
    input  logic [4:0]                  PA_log_count,
    input  logic                        PA_clear,
    input  logic                        S_AXIS_tvalid,
    input  logic [AXIS_TDATA_WIDTH-1:0] S_AXIS_tdata,
    output logic                        S_AXIS_tready,
    output logic                        M_AXIS_tvalid,
    output logic [AXIS_TDATA_WIDTH-1:0] M_AXIS_tdata,
    input  logic                        M_AXIS_tready,
    output logic [31:0]                 PA_result_count
);

    localparam int W  = AXIS_TDATA_WIDTH;
    localparam int AW = AXIS_TDATA_WIDTH + 16;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACCUMULATE = 2'd1,
        OUTPUT     = 2'd2
    } state_t;

    // Block sizes beyond 2^16 would need a wider accumulator, so saturate k.
    function automatic logic [4:0] clamp_k(input logic [4:0] raw);
        if (raw > 5'd16) begin
            return 5'd16;
        end else begin
            return raw;
        end
    endfunction

    state_t          state_q, state_d;
    logic [4:0]      k_q, k_d;
    logic [AW-1:0]   acc_q, acc_d;
    logic [16:0]     cnt_q, cnt_d;
    logic            s_tready_q, s_tready_d;
    logic            m_tvalid_q, m_tvalid_d;
    logic [W-1:0]    m_tdata_q, m_tdata_d;
    logic [31:0]     result_count_q, result_count_d;

    logic            accept_s;
    logic            handshake_s;
    logic            last_s;
    logic            start_block_s;
    logic [AW-1:0]   sum_s;

    // Next-state computation for the block FSM, accumulator and output stage.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        acc_d          = acc_q;
        cnt_d          = cnt_q;
        m_tvalid_d     = m_tvalid_q;
        m_tdata_d      = m_tdata_q;
        start_block_s  = 1'b0;

        accept_s    = S_AXIS_tvalid & s_tready_q & ~PA_clear;
        handshake_s = m_tvalid_q & M_AXIS_tready;
        sum_s       = acc_q + {16'd0, S_AXIS_tdata};
        last_s      = ((cnt_q + 17'd1) == (17'd1 << k_q));

        if (handshake_s) begin
            result_count_d = result_count_q + 32'd1;
        end else begin
            result_count_d = result_count_q;
        end

        case (state_q)
            IDLE: begin
                start_block_s = 1'b1;
            end
            ACCUMULATE: begin
                if (accept_s && last_s) begin
                    m_tdata_d  = W'(sum_s >> k_q);
                    m_tvalid_d = 1'b1;
                    state_d    = OUTPUT;
                end else if (accept_s) begin
                    acc_d = sum_s;
                    cnt_d = cnt_q + 17'd1;
                end else begin
                    acc_d = acc_q;
                end
            end
            OUTPUT: begin
                if (handshake_s) begin
                    start_block_s = 1'b1;
                end else begin
                    start_block_s = 1'b0;
                end
            end
            default: begin
                start_block_s = 1'b1;
            end
        endcase

        // A clear overrides everything except the handshake count above.
        if (PA_clear || start_block_s) begin
            state_d    = ACCUMULATE;
            k_d        = clamp_k(PA_log_count);
            acc_d      = {AW{1'b0}};
            cnt_d      = 17'd0;
            m_tvalid_d = 1'b0;
        end else begin
            k_d = k_q;
        end

        s_tready_d = (state_d == ACCUMULATE);
    end

    // State register with asynchronous discard of all partial state.
    always_ff @(posedge SYS_aclk or negedge SYS_aresetn) begin
        if (!SYS_aresetn) begin
            state_q        <= IDLE;
            k_q            <= 5'd0;
            acc_q          <= {AW{1'b0}};
            cnt_q          <= 17'd0;
            s_tready_q     <= 1'b0;
            m_tvalid_q     <= 1'b0;
            m_tdata_q      <= {W{1'b0}};
            result_count_q <= 32'd0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            acc_q          <= acc_d;
            cnt_q          <= cnt_d;
            s_tready_q     <= s_tready_d;
            m_tvalid_q     <= m_tvalid_d;
            m_tdata_q      <= m_tdata_d;
            result_count_q <= result_count_d;
        end
    end

    assign S_AXIS_tready   = s_tready_q;
    assign M_AXIS_tvalid   = m_tvalid_q;
    assign M_AXIS_tdata    = m_tdata_q;
    assign PA_result_count = result_count_q;

endmodule

// File: tb/tb_period_averager.sv
// Self-checking bench for period_averager: a block-level reference model checked
// every cycle, plus literal expectations for each directed scenario.
module tb_period_averager;

    localparam int W = 32;

    logic         clk       = 1'b0;
    logic         rst_n     = 1'b1;
    logic [4:0]   log_count = 5'd0;
    logic         clear     = 1'b0;
    logic         s_tvalid  = 1'b0;
    logic [W-1:0] s_tdata   = '0;
    logic         s_tready;
    logic         m_tvalid;
    logic [W-1:0] m_tdata;
    logic         m_tready  = 1'b1;
    logic [31:0]  rc;

    int n_cmp = 0;
    int n_err = 0;
    bit chk_en = 1'b0;
    logic [W-1:0] got[$];

    // Reference model state: what a block averager must look like from outside.
    bit           md_idle  = 1'b1;
    bit           md_ready = 1'b0;
    bit           md_valid = 1'b0;
    logic [W-1:0] md_data  = '0;
    logic [31:0]  md_rc    = 32'd0;
    logic [63:0]  md_sum   = 64'd0;
    int           md_cnt   = 0;
    int           md_k     = 0;

    period_averager #(.AXIS_TDATA_WIDTH(W)) dut (
        .SYS_aclk        (clk),
        .SYS_aresetn     (rst_n),
        .PA_log_count    (log_count),
        .PA_clear        (clear),
        .S_AXIS_tvalid   (s_tvalid),
        .S_AXIS_tdata    (s_tdata),
        .S_AXIS_tready   (s_tready),
        .M_AXIS_tvalid   (m_tvalid),
        .M_AXIS_tdata    (m_tdata),
        .M_AXIS_tready   (m_tready),
        .PA_result_count (rc)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model update: a block of 2^k samples yields one averaged result.
    always @(posedge clk or negedge rst_n) begin
        logic [63:0] nsum;
        int          ncnt;
        int          nk;
        bit          hs;
        if (!rst_n) begin
            md_idle  <= 1'b1;
            md_ready <= 1'b0;
            md_valid <= 1'b0;
            md_data  <= '0;
            md_rc    <= 32'd0;
            md_sum   <= 64'd0;
            md_cnt   <= 0;
            md_k     <= 0;
        end else begin
            hs = md_valid && m_tready;
            nk = (int'(log_count) > 16) ? 16 : int'(log_count);
            if (hs) md_rc <= md_rc + 32'd1;
            if (clear || md_idle || hs) begin
                md_idle  <= 1'b0;
                md_k     <= nk;
                md_sum   <= 64'd0;
                md_cnt   <= 0;
                md_ready <= 1'b1;
                md_valid <= 1'b0;
            end else if (md_ready && s_tvalid) begin
                nsum = md_sum + 64'(s_tdata);
                ncnt = md_cnt + 1;
                md_sum <= nsum;
                md_cnt <= ncnt;
                if (ncnt == (1 << md_k)) begin
                    md_data  <= W'(nsum >> md_k);
                    md_valid <= 1'b1;
                    md_ready <= 1'b0;
                end
            end
        end
    end

    // Per-cycle comparison of DUT outputs against the model; logs delivered results.
    always @(negedge clk) begin
        if (chk_en) begin
            check("cyc_s_tready", 64'(s_tready), 64'(md_ready));
            check("cyc_m_tvalid", 64'(m_tvalid), 64'(md_valid));
            check("cyc_result_count", 64'(rc), 64'(md_rc));
            if (md_valid || !rst_n) check("cyc_m_tdata", 64'(m_tdata), 64'(md_data));
            if (m_tvalid && m_tready) got.push_back(m_tdata);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send(input logic [W-1:0] d);
        bit ok;
        ok = 1'b0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        for (int i = 0; i < 200 && !ok; i++) begin
            ok = s_tready && !clear;
            tick();
        end
        if (!ok) check("send_timeout", 64'd0, 64'd1);
        s_tvalid = 1'b0;
    endtask

    task automatic pulse_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic expect_one(input string name, input logic [W-1:0] exp, input logic [31:0] exp_rc);
        check({name, "_count"}, 64'(got.size()), 64'd1);
        if (got.size() >= 1) check({name, "_value"}, 64'(got[0]), 64'(exp));
        check({name, "_rc"}, 64'(rc), 64'(exp_rc));
        got.delete();
    endtask

    initial begin
        #1 rst_n = 1'b0;
        tick();
        chk_en = 1'b1;
        tick();
        check("rst_s_tready", 64'(s_tready), 64'd0);
        check("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("rst_m_tdata", 64'(m_tdata), 64'd0);
        check("rst_rc", 64'(rc), 64'd0);

        // Leave reset; one idle cycle precedes accumulation.
        log_count = 5'd2;
        rst_n = 1'b1;
        #1 check("idle_tready_low", 64'(s_tready), 64'd0);
        tick();
        check("acc_tready_high", 64'(s_tready), 64'd1);

        // k=2: 100,101,102,105 -> 102
        send(32'd100); send(32'd101); send(32'd102); send(32'd105);
        repeat (4) tick();
        expect_one("k2_avg", 32'd102, 32'd1);

        // k=0 pass-through, back to back
        log_count = 5'd0;
        pulse_clear();
        send(32'd7); send(32'd9);
        repeat (4) tick();
        check("k0_count", 64'(got.size()), 64'd2);
        if (got.size() >= 2) begin
            check("k0_first", 64'(got[0]), 64'd7);
            check("k0_second", 64'(got[1]), 64'd9);
        end
        check("k0_rc", 64'(rc), 64'd3);
        got.delete();

        // k=1 with downstream stalled for 10 cycles: result held, source blocked
        log_count = 5'd1;
        m_tready = 1'b0;
        pulse_clear();
        send(32'd20); send(32'd31);
        s_tvalid = 1'b1;
        s_tdata  = 32'd99;
        repeat (10) tick();
        check("stall_tvalid", 64'(m_tvalid), 64'd1);
        check("stall_tdata", 64'(m_tdata), 64'd25);
        check("stall_tready", 64'(s_tready), 64'd0);
        s_tvalid = 1'b0;
        m_tready = 1'b1;
        repeat (3) tick();
        expect_one("stall_avg", 32'd25, 32'd4);

        // k=3: clear after 5 samples (sample offered during clear ignored), k change mid-block ignored
        log_count = 5'd3;
        pulse_clear();
        for (int i = 0; i < 5; i++) send(32'd1000);
        s_tvalid = 1'b1;
        s_tdata  = 32'd5000;
        pulse_clear();
        s_tvalid = 1'b0;
        for (int i = 0; i < 3; i++) send(32'd40);
        log_count = 5'd0;
        for (int i = 0; i < 5; i++) send(32'd40);
        repeat (4) tick();
        expect_one("clear_avg", 32'd40, 32'd5);

        // zero-valued samples count like any other
        log_count = 5'd1;
        pulse_clear();
        send(32'd0); send(32'd6);
        repeat (3) tick();
        expect_one("zero_avg", 32'd3, 32'd6);

        // k requested as 20 clamps to 16: 65536 maximal samples without overflow
        log_count = 5'd20;
        pulse_clear();
        for (int i = 0; i < 65536; i++) send(32'hFFFF_FFFF);
        repeat (4) tick();
        expect_one("k16_avg", 32'hFFFF_FFFF, 32'd7);

        // reset mid-block discards everything immediately
        log_count = 5'd2;
        pulse_clear();
        send(32'd77); send(32'd77);
        rst_n = 1'b0;
        #1;
        check("arst_s_tready", 64'(s_tready), 64'd0);
        check("arst_m_tvalid", 64'(m_tvalid), 64'd0);
        check("arst_m_tdata", 64'(m_tdata), 64'd0);
        check("arst_rc", 64'(rc), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) send(32'd10);
        repeat (4) tick();
        expect_one("post_rst_avg", 32'd10, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
